debug_commit_tracer: RTL and testbench

DEBUG_COMMIT_TRACER -- requirements
Module: debug_commit_tracer

---
 rtl/debug_commit_tracer_pkg.sv | 39 +++
 rtl/commit_trace_queue.sv | 81 ++++++++
 rtl/debug_commit_tracer.sv | 189 ++++++++++++++++++
 tb/tb_debug_commit_tracer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_commit_tracer_pkg.sv
// Shared types for the commit tracer.
// Defines the per-op trace record (CommitTraceEntry), the tracer phase
// encoding (TracerPhase), the default queue depth and the field widths
// that the commit-stage interface uses.
package debug_commit_tracer_pkg;

    localparam int COMMIT_WIDTH    = 2;
    localparam int TRACE_ENTRY_NUM = 16;

    localparam int OP_SERIAL_WIDTH = 10;
    localparam int PC_WIDTH        = 32;
    localparam int LREG_NUM_WIDTH  = 5;
    localparam int PREG_NUM_WIDTH  = 7;

    typedef logic [OP_SERIAL_WIDTH-1:0] OpSerial;
    typedef logic [PC_WIDTH-1:0]        PC_Path;
    typedef logic [LREG_NUM_WIDTH-1:0]  LRegNumPath;
    typedef logic [PREG_NUM_WIDTH-1:0]  PRegNumPath;

    // Committing an op at this pc ends the trace window.
    localparam PC_Path PC_GOAL = 32'h0000_0800;

    typedef struct packed {
        OpSerial     sid;
        PC_Path      pc;
        logic        writeReg;
        LRegNumPath  logDst;
        PRegNumPath  phyDst;
        logic [31:0] cycle;
    } CommitTraceEntry;

    typedef enum logic [1:0] {
        PHASE_DISABLED = 2'd0,
        PHASE_ACTIVE   = 2'd1,
        PHASE_HALTED   = 2'd2,
        PHASE_DONE     = 2'd3
    } TracerPhase;

endpackage

// File: rtl/commit_trace_queue.sv
// Circular buffer with up to LANE_NUM pushes and one pop per cycle.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push_num    number of valid entries in push_entry (already compacted,
//               slot 0 first); caller guarantees they fit
//   push_entry  compacted entries to append
//   pop         remove head (ignored when empty)
//   out_valid   queue not empty
//   out_entry   head entry
//   count       occupancy
module commit_trace_queue
    import debug_commit_tracer_pkg::*;
#(
    parameter int ENTRY_NUM = TRACE_ENTRY_NUM,
    parameter int LANE_NUM  = COMMIT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [$clog2(LANE_NUM+1)-1:0]        push_num,
    input  CommitTraceEntry [LANE_NUM-1:0]       push_entry,
    input  logic                                 pop,
    output logic                                 out_valid,
    output CommitTraceEntry                      out_entry,
    output logic [$clog2(ENTRY_NUM):0]           count
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;
    localparam int NUM_W = $clog2(LANE_NUM + 1);

    CommitTraceEntry  mem_q [ENTRY_NUM];
    CommitTraceEntry  mem_d [ENTRY_NUM];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_s;

    assign pop_s     = pop & (count_q != {CNT_W{1'b0}});
    assign out_valid = (count_q != {CNT_W{1'b0}});
    assign out_entry = mem_q[head_q];
    assign count     = count_q;

    // Next storage, pointer and occupancy values.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < LANE_NUM; k++) begin
            if (NUM_W'(k) < push_num) begin
                // Pointer arithmetic wraps naturally since depth is 2^PTR_W.
                mem_d[tail_q + PTR_W'(k)] = push_entry[k];
            end else begin
                mem_d[tail_q + PTR_W'(k)] = mem_q[tail_q + PTR_W'(k)];
            end
        end
        tail_d = tail_q + PTR_W'(push_num);
        if (pop_s) begin
            head_d = head_q + PTR_W'(1'b1);
        end else begin
            head_d = head_q;
        end
        count_d = count_q + CNT_W'(push_num) - CNT_W'(pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/debug_commit_tracer.sv
// Records committed ops into a trace queue until the goal pc commits.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   allow capture (DISABLED <-> ACTIVE)
//   cmCommit/cmFlush         per-lane commit and flush flags
//   cmSid/cmPC/cmWriteReg/
//   cmLogDst/cmPhyDst        per-lane op fields recorded in the entry
//   outValid/outReady/outEntry  head-of-queue handshake
//   entryCount               queue occupancy
//   dropCount                ops lost to a full queue, saturating
//   overflow                 sticky: at least one group was dropped
//   done                     goal seen and the queue has drained
module debug_commit_tracer
    import debug_commit_tracer_pkg::*;
#(
    parameter int ENTRY_NUM = TRACE_ENTRY_NUM,
    parameter int LANE_NUM  = COMMIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [LANE_NUM-1:0]            cmCommit,
    input  logic [LANE_NUM-1:0]            cmFlush,
    input  OpSerial [LANE_NUM-1:0]         cmSid,
    input  PC_Path [LANE_NUM-1:0]          cmPC,
    input  logic [LANE_NUM-1:0]            cmWriteReg,
    input  LRegNumPath [LANE_NUM-1:0]      cmLogDst,
    input  PRegNumPath [LANE_NUM-1:0]      cmPhyDst,
    output logic                           outValid,
    input  logic                           outReady,
    output CommitTraceEntry                outEntry,
    output logic [$clog2(ENTRY_NUM):0]     entryCount,
    output logic [31:0]                    dropCount,
    output logic                           overflow,
    output logic                           done
);

    localparam int CNT_W = $clog2(ENTRY_NUM) + 1;
    localparam int NUM_W = $clog2(LANE_NUM + 1);

    TracerPhase                  phase_q, phase_d;
    logic [31:0]                 cycle_q, cycle_d;
    logic [31:0]                 drop_q, drop_d;
    logic                        overflow_q, overflow_d;
    logic                        done_q, done_d;

    logic [LANE_NUM-1:0]         take_s;
    logic                        goal_s;
    logic [NUM_W-1:0]            take_num_s;
    logic [NUM_W-1:0]            push_num_s;
    logic                        fits_s;
    logic [32:0]                 drop_sum_s;
    logic                        pop_s;
    logic [CNT_W-1:0]            count_s;
    CommitTraceEntry [LANE_NUM-1:0] push_entry_s;

    assign pop_s      = outValid & outReady;
    assign entryCount = count_s;
    assign dropCount  = drop_q;
    assign overflow   = overflow_q;
    assign done       = done_q;

    // Accepted lanes; a goal lane masks every higher lane in the same cycle.
    always_comb begin
        take_s     = {LANE_NUM{1'b0}};
        goal_s     = 1'b0;
        take_num_s = {NUM_W{1'b0}};
        for (int i = 0; i < LANE_NUM; i++) begin
            if ((phase_q == PHASE_ACTIVE) && cmCommit[i] && !cmFlush[i] && !goal_s) begin
                take_s[i]  = 1'b1;
                take_num_s = take_num_s + NUM_W'(1'b1);
                if (cmPC[i] == PC_GOAL) begin
                    goal_s = 1'b1;
                end else begin
                    goal_s = goal_s;
                end
            end else begin
                take_s[i] = 1'b0;
            end
        end
    end

    // Pack accepted lanes into consecutive slots, lowest lane first.
    always_comb begin
        int filled;
        push_entry_s = {($bits(CommitTraceEntry) * LANE_NUM){1'b0}};
        filled       = 0;
        for (int i = 0; i < LANE_NUM; i++) begin
            for (int s = 0; s < LANE_NUM; s++) begin
                if (take_s[i] && (filled == s)) begin
                    push_entry_s[s] = '{sid:      cmSid[i],
                                        pc:       cmPC[i],
                                        writeReg: cmWriteReg[i],
                                        logDst:   cmLogDst[i],
                                        phyDst:   cmPhyDst[i],
                                        cycle:    cycle_q};
                end else begin
                    push_entry_s[s] = push_entry_s[s];
                end
            end
            if (take_s[i]) begin
                filled = filled + 1;
            end else begin
                filled = filled;
            end
        end
    end

    // All-or-nothing admission against the registered free space; a pop in
    // the same cycle deliberately does not make room.
    always_comb begin
        fits_s = (32'(take_num_s) <= (32'(ENTRY_NUM) - 32'(count_s)));
        if (fits_s) begin
            push_num_s = take_num_s;
        end else begin
            push_num_s = {NUM_W{1'b0}};
        end
    end

    // Cycle stamp, drop statistics and phase transitions.
    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        drop_sum_s = {1'b0, drop_q} + 33'(take_num_s);
        if (!fits_s) begin
            drop_d     = drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
            overflow_d = 1'b1;
        end else begin
            drop_d     = drop_q;
            overflow_d = overflow_q;
        end

        phase_d = phase_q;
        case (phase_q)
            PHASE_DISABLED: begin
                if (enable) phase_d = PHASE_ACTIVE;
                else        phase_d = PHASE_DISABLED;
            end
            PHASE_ACTIVE: begin
                // The goal wins even when its group was dropped.
                if (goal_s)       phase_d = PHASE_HALTED;
                else if (!enable) phase_d = PHASE_DISABLED;
                else              phase_d = PHASE_ACTIVE;
            end
            PHASE_HALTED: begin
                if (count_s == {CNT_W{1'b0}}) phase_d = PHASE_DONE;
                else                          phase_d = PHASE_HALTED;
            end
            PHASE_DONE: begin
                phase_d = PHASE_DONE;
            end
            default: begin
                phase_d = PHASE_DISABLED;
            end
        endcase
        done_d = (phase_d == PHASE_DONE);
    end

    // Control and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PHASE_DISABLED;
            cycle_q    <= 32'd0;
            drop_q     <= 32'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cycle_q    <= cycle_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    commit_trace_queue #(
        .ENTRY_NUM (ENTRY_NUM),
        .LANE_NUM  (LANE_NUM)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_num   (push_num_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .out_valid  (outValid),
        .out_entry  (outEntry),
        .count      (count_s)
    );

endmodule

// File: tb/tb_debug_commit_tracer.sv
module tb_debug_commit_tracer;
    import debug_commit_tracer_pkg::*;

    localparam int LN = 2;
    localparam int EN = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [LN-1:0]        cmCommit;
    logic [LN-1:0]        cmFlush;
    OpSerial [LN-1:0]     cmSid;
    PC_Path [LN-1:0]      cmPC;
    logic [LN-1:0]        cmWriteReg;
    LRegNumPath [LN-1:0]  cmLogDst;
    PRegNumPath [LN-1:0]  cmPhyDst;
    logic                 outValid;
    logic                 outReady;
    CommitTraceEntry      outEntry;
    logic [2:0]           entryCount;
    logic [31:0]          dropCount;
    logic                 overflow;
    logic                 done;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;

    debug_commit_tracer #(.ENTRY_NUM(EN), .LANE_NUM(LN)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cmCommit   (cmCommit),
        .cmFlush    (cmFlush),
        .cmSid      (cmSid),
        .cmPC       (cmPC),
        .cmWriteReg (cmWriteReg),
        .cmLogDst   (cmLogDst),
        .cmPhyDst   (cmPhyDst),
        .outValid   (outValid),
        .outReady   (outReady),
        .outEntry   (outEntry),
        .entryCount (entryCount),
        .dropCount  (dropCount),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; signals are sampled and driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_lanes(input logic [1:0] c, input logic [1:0] f,
                             input int s0, input int s1,
                             input logic [31:0] p0, input logic [31:0] p1);
        cmCommit    = c;
        cmFlush     = f;
        cmSid[0]    = OpSerial'(s0);
        cmSid[1]    = OpSerial'(s1);
        cmPC[0]     = p0;
        cmPC[1]     = p1;
        cmWriteReg  = 2'b01;
        cmLogDst[0] = 5'd3;
        cmLogDst[1] = 5'd4;
        cmPhyDst[0] = 7'd33;
        cmPhyDst[1] = 7'd34;
    endtask

    task automatic idle();
        set_lanes(2'b00, 2'b00, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        outReady = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;

        // Reset state
        check_eq("rst_valid", outValid, 1'b0);
        check_eq("rst_count", entryCount, 3'd0);
        check_eq("rst_drop", dropCount, 32'd0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_phase", dut.phase_q, PHASE_DISABLED);

        // Two-lane commit in cycle 10, drained with outReady held high
        enable   = 1'b1;
        outReady = 1'b1;
        while (cyc < 10) tick();
        set_lanes(2'b11, 2'b00, 5, 6, 32'h100, 32'h104);
        tick();
        idle();
        check_eq("s1_valid", outValid, 1'b1);
        check_eq("s1_count2", entryCount, 3'd2);
        check_eq("s1_sid5", outEntry.sid, 10'd5);
        check_eq("s1_stamp", outEntry.cycle, 32'd10);
        check_eq("s1_pc", outEntry.pc, 32'h100);
        check_eq("s1_wreg", outEntry.writeReg, 1'b1);
        check_eq("s1_phy", outEntry.phyDst, 7'd33);
        tick();
        check_eq("s1_count1", entryCount, 3'd1);
        check_eq("s1_sid6", outEntry.sid, 10'd6);
        check_eq("s1_stamp6", outEntry.cycle, 32'd10);
        check_eq("s1_log6", outEntry.logDst, 5'd4);
        tick();
        check_eq("s1_count0", entryCount, 3'd0);
        check_eq("s1_empty", outValid, 1'b0);

        // Flushed lane 0 leaves no hole
        outReady = 1'b0;
        set_lanes(2'b11, 2'b01, 8, 9, 32'h200, 32'h204);
        tick();
        idle();
        check_eq("s2_count", entryCount, 3'd1);
        check_eq("s2_sid9", outEntry.sid, 10'd9);
        outReady = 1'b1;
        tick();
        check_eq("s2_drain", entryCount, 3'd0);

        // Fill to capacity, third group dropped whole
        outReady = 1'b0;
        set_lanes(2'b11, 2'b00, 20, 21, 32'h300, 32'h304);
        tick();
        set_lanes(2'b11, 2'b00, 22, 23, 32'h308, 32'h30c);
        tick();
        check_eq("s3_count4a", entryCount, 3'd4);
        set_lanes(2'b11, 2'b00, 24, 25, 32'h310, 32'h314);
        tick();
        idle();
        check_eq("s3_count4", entryCount, 3'd4);
        check_eq("s3_drop2", dropCount, 32'd2);
        check_eq("s3_ovf", overflow, 1'b1);
        check_eq("s3_head20", outEntry.sid, 10'd20);
        tick();
        check_eq("s3_stable", outEntry.sid, 10'd20);

        // Pop to 3, then pop + 2-lane push in one cycle: space is 1, group dropped
        outReady = 1'b1;
        tick();
        check_eq("s4_count3", entryCount, 3'd3);
        check_eq("s4_head21", outEntry.sid, 10'd21);
        set_lanes(2'b11, 2'b00, 30, 31, 32'h400, 32'h404);
        tick();
        idle();
        check_eq("s4_count2", entryCount, 3'd2);
        check_eq("s4_drop4", dropCount, 32'd4);
        check_eq("s4_head22", outEntry.sid, 10'd22);
        tick();
        check_eq("s4_head23", outEntry.sid, 10'd23);
        tick();
        check_eq("s4_drain", entryCount, 3'd0);

        // Goal on lane 0: lane 1 ignored without counting as a drop
        outReady = 1'b0;
        set_lanes(2'b11, 2'b00, 40, 41, PC_GOAL, 32'h500);
        tick();
        check_eq("s5_count1", entryCount, 3'd1);
        check_eq("s5_head40", outEntry.sid, 10'd40);
        check_eq("s5_nodrop", dropCount, 32'd4);
        check_eq("s5_halted", dut.phase_q, PHASE_HALTED);
        set_lanes(2'b01, 2'b00, 42, 43, 32'h600, 32'h604);
        tick();
        idle();
        check_eq("s5_ignored", entryCount, 3'd1);
        check_eq("s5_drop_same", dropCount, 32'd4);
        outReady = 1'b1;
        tick();
        check_eq("s5_empty", entryCount, 3'd0);
        check_eq("s5_done_low", done, 1'b0);
        tick();
        check_eq("s5_done", done, 1'b1);
        check_eq("s5_phase_done", dut.phase_q, PHASE_DONE);
        tick();
        check_eq("s5_done_hold", done, 1'b1);

        // Mid-operation reset with 3 entries queued and a drop recorded
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("s6_done_clr", done, 1'b0);
        outReady = 1'b0;
        tick();
        set_lanes(2'b11, 2'b00, 50, 51, 32'h700, 32'h704);
        tick();
        set_lanes(2'b01, 2'b00, 52, 0, 32'h708, 32'h0);
        tick();
        check_eq("s6_count3", entryCount, 3'd3);
        set_lanes(2'b11, 2'b00, 53, 54, 32'h70c, 32'h710);
        tick();
        check_eq("s6_drop2", dropCount, 32'd2);
        rst      = 1'b1;
        outReady = 1'b1;
        set_lanes(2'b11, 2'b00, 55, 56, 32'h714, 32'h718);
        tick();
        rst = 1'b0;
        idle();
        check_eq("s6_valid0", outValid, 1'b0);
        check_eq("s6_count0", entryCount, 3'd0);
        check_eq("s6_drop0", dropCount, 32'd0);
        check_eq("s6_ovf0", overflow, 1'b0);
        check_eq("s6_phase", dut.phase_q, PHASE_DISABLED);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
